// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART transmitter definitions: FSM state encoding,
//                parity mode codes and common baud divisors.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Transmitter FSM states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } uart_state_t;

   // Parity mode codes for the PARITY parameter
   localparam int c_PARITY_NONE = 0;
   localparam int c_PARITY_ODD  = 1;
   localparam int c_PARITY_EVEN = 2;

   // Clocks-per-bit divisors for common system clocks
   localparam int c_DIV_50M_9600   = 5208;
   localparam int c_DIV_50M_115200 = 434;
   localparam int c_DIV_12M_9600   = 1250;
   localparam int c_DIV_12M_115200 = 104;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO with registered full, empty
//                and level flags and a one-cycle overflow pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_wr_en,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_rd_en,
   output logic [WIDTH-1:0]           o_rd_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic [AW:0]      w_level_next;
   logic             r_full;
   logic             r_empty;
   logic             r_overflow;
   logic             w_wr_acc;
   logic             w_rd_acc;

   // Writes are gated by the registered full flag only, so a pop in the
   // same cycle does not make room for a write to a full FIFO.
   assign w_wr_acc = i_wr_en && !r_full;
   assign w_rd_acc = i_rd_en && !r_empty;

   // Next occupancy: a simultaneous write and read cancel out
   always_comb begin
      w_level_next = r_level;
      if (w_wr_acc && !w_rd_acc) begin
         w_level_next = r_level + 1'b1;
      end else if (!w_wr_acc && w_rd_acc) begin
         w_level_next = r_level - 1'b1;
      end
   end

   // Pointers, occupancy and flags; flags derive from the next level so
   // they always agree with level in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level    <= w_level_next;
         r_full     <= (w_level_next == (AW+1)'(DEPTH));
         r_empty    <= (w_level_next == '0);
         r_overflow <= i_wr_en && r_full;
      end
   end

   // Storage array; contents are discarded on reset via the pointers
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_full     = r_full;
   assign o_empty    = r_empty;
   assign o_level    = r_level;
   assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter fed by a character FIFO. Frames are sent
//                back to back while characters are queued.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 104,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [DATA_BITS-1:0]          wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          busy,
   output logic                          tx_done,
   output logic                          tx_pin
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int IDX_W = 4;
   localparam logic [CNT_W-1:0] c_CNT_RELOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] c_DATA_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] c_STOP_LAST  = IDX_W'(STOP_BITS - 1);

   uart_state_t          r_state,  w_state_next;
   logic [CNT_W-1:0]     r_cnt,    w_cnt_next;
   logic [IDX_W-1:0]     r_idx,    w_idx_next;
   logic [DATA_BITS-1:0] r_shift,  w_shift_next;
   logic                 r_parity, w_parity_next;
   logic                 r_tx_pin, w_tx_next;
   logic                 w_pop;
   logic                 w_tx_done;
   logic                 w_start_frame;
   logic                 w_bit_end;
   logic                 w_empty;
   logic [DATA_BITS-1:0] w_rd_data;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (wr_en),
      .i_wr_data  (wr_data),
      .i_rd_en    (w_pop),
      .o_rd_data  (w_rd_data),
      .o_full     (full),
      .o_empty    (w_empty),
      .o_level    (level),
      .o_overflow (overflow)
   );

   assign w_bit_end = (r_cnt == '0);

   // Next-state, bit sequencing and next line level for the serial output
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_idx_next    = r_idx;
      w_shift_next  = r_shift;
      w_parity_next = r_parity;
      w_tx_next     = r_tx_pin;
      w_pop         = 1'b0;
      w_tx_done     = 1'b0;
      w_start_frame = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_tx_next     = 1'b1;
            w_start_frame = !w_empty;
         end
         ST_START: begin
            if (w_bit_end) begin
               w_state_next = ST_DATA;
               w_cnt_next   = c_CNT_RELOAD;
               w_idx_next   = '0;
               w_tx_next    = r_shift[0];
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_cnt_next = c_CNT_RELOAD;
               if (r_idx == c_DATA_LAST) begin
                  w_idx_next = '0;
                  if (PARITY != c_PARITY_NONE) begin
                     w_state_next = ST_PAR;
                     w_tx_next    = r_parity;
                  end else begin
                     w_state_next = ST_STOP;
                     w_tx_next    = 1'b1;
                  end
               end else begin
                  w_idx_next   = r_idx + 1'b1;
                  w_shift_next = r_shift >> 1;
                  w_tx_next    = r_shift[1];
               end
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_PAR: begin
            if (w_bit_end) begin
               w_state_next = ST_STOP;
               w_cnt_next   = c_CNT_RELOAD;
               w_idx_next   = '0;
               w_tx_next    = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               if (r_idx == c_STOP_LAST) begin
                  w_tx_done = 1'b1;
                  if (w_empty) begin
                     w_state_next = ST_IDLE;
                     w_tx_next    = 1'b1;
                  end else begin
                     w_start_frame = 1'b1;
                  end
               end else begin
                  w_idx_next = r_idx + 1'b1;
                  w_cnt_next = c_CNT_RELOAD;
               end
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_tx_next    = 1'b1;
         end
      endcase

      // Pop the next character and drive the start bit from the next clock
      if (w_start_frame) begin
         w_pop         = 1'b1;
         w_shift_next  = w_rd_data;
         w_parity_next = (^w_rd_data) ^ (PARITY == c_PARITY_ODD);
         w_state_next  = ST_START;
         w_cnt_next    = c_CNT_RELOAD;
         w_idx_next    = '0;
         w_tx_next     = 1'b0;
      end
   end

   // FSM, counters and registered serial output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx_pin <= 1'b1;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_idx    <= w_idx_next;
         r_shift  <= w_shift_next;
         r_parity <= w_parity_next;
         r_tx_pin <= w_tx_next;
      end
   end

   assign empty   = w_empty;
   assign busy    = (r_state != ST_IDLE);
   assign tx_done = w_tx_done;
   assign tx_pin  = r_tx_pin;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. Four instances cover
//                default framing, even/odd parity and a short 7-bit frame
//                with two stop bits. Expected characters are queued on write
//                and compared against frames decoded from tx_pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst_n;
   logic [3:0] wr_en;
   logic [8:0] wd [4];
   logic [3:0] full, empty, overflow, busy, tx_done, tx_pin;
   logic [4:0] level [4];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int n_done0 = 0;
   int n_ovf0 = 0;
   logic [8:0] sb_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and event counters for instance 0
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_done[0])  n_done0 <= n_done0 + 1;
      if (overflow[0]) n_ovf0  <= n_ovf0 + 1;
   end

   uart_tx_fifo u_dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wd[0][7:0]),
      .full(full[0]), .empty(empty[0]), .level(level[0]), .overflow(overflow[0]),
      .busy(busy[0]), .tx_done(tx_done[0]), .tx_pin(tx_pin[0]));

   uart_tx_fifo #(.PARITY(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wd[1][7:0]),
      .full(full[1]), .empty(empty[1]), .level(level[1]), .overflow(overflow[1]),
      .busy(busy[1]), .tx_done(tx_done[1]), .tx_pin(tx_pin[1]));

   uart_tx_fifo #(.PARITY(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wd[2][7:0]),
      .full(full[2]), .empty(empty[2]), .level(level[2]), .overflow(overflow[2]),
      .busy(busy[2]), .tx_done(tx_done[2]), .tx_pin(tx_pin[2]));

   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en[3]), .wr_data(wd[3][6:0]),
      .full(full[3]), .empty(empty[3]), .level(level[3]), .overflow(overflow[3]),
      .busy(busy[3]), .tx_done(tx_done[3]), .tx_pin(tx_pin[3]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One write cycle starting at a negedge; push to the scoreboard if it is
   // expected to be accepted
   task automatic wr(input int sel, input logic [8:0] d, input bit push);
      wr_en[sel] = 1'b1;
      wd[sel]    = d;
      if (push) sb_q.push_back(d);
      @(negedge clk);
      wr_en[sel] = 1'b0;
   endtask

   // Decode one frame from tx_pin[sel], checking every clock of it
   task automatic rx_frame(input int sel, input int cdiv, input int dbits,
                           input int par, input int sbits, input bit started,
                           output int t0, output logic rx_par);
      int len, bad, bad_done, ones;
      bit seen;
      logic [15:0] exp_bits, rx_bits;
      logic [8:0]  exp_data;
      len    = (1 + dbits + ((par != 0) ? 1 : 0) + sbits) * cdiv;
      rx_par = 1'b0;
      t0     = -1;
      seen   = started;
      for (int k = 0; k < 4000 && !seen; k++) begin
         @(negedge clk);
         if (tx_pin[sel] == 1'b0) seen = 1'b1;
      end
      if (!seen) begin
         check_val("start_timeout", 32'd0, 32'd1);
         return;
      end
      t0 = cyc;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd0, 32'd1);
         exp_data = '0;
      end else begin
         exp_data = sb_q.pop_front();
      end
      exp_bits    = '1;
      exp_bits[0] = 1'b0;
      ones        = 0;
      for (int i = 0; i < dbits; i++) begin
         exp_bits[1+i] = exp_data[i];
         if (exp_data[i]) ones++;
      end
      if (par == 2) exp_bits[1+dbits] = (ones % 2 == 1);
      if (par == 1) exp_bits[1+dbits] = (ones % 2 == 0);
      rx_bits  = '1;
      bad      = 0;
      bad_done = 0;
      for (int c = 0; c < len; c++) begin
         if (c > 0) @(negedge clk);
         if (tx_pin[sel] !== exp_bits[c/cdiv]) bad++;
         if (c % cdiv == cdiv / 2) rx_bits[c/cdiv] = tx_pin[sel];
         if (tx_done[sel] !== (c == len - 1)) bad_done++;
      end
      if (par != 0) rx_par = rx_bits[1+dbits];
      check_val("frame_bits", 32'(rx_bits), 32'(exp_bits));
      check_val("bit_timing", bad, 0);
      check_val("tx_done_pos", bad_done, 0);
   endtask

   initial begin
      int t [20];
      int d0, o0;
      logic p;
      bit seen;

      rst_n = 1'b0;
      wr_en = '0;
      for (int i = 0; i < 4; i++) wd[i] = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check_val("rst_tx_pin", tx_pin[0], 1);
      check_val("rst_busy", busy[0], 0);
      check_val("rst_empty", empty[0], 1);
      check_val("rst_full", full[0], 0);
      check_val("rst_level", level[0], 0);
      check_val("rst_ovf", overflow[0], 0);
      check_val("rst_done", tx_done[0], 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("idle_tx_pin", tx_pin[0], 1);

      // Three back-to-back frames from consecutive writes
      d0 = n_done0;
      fork
         begin wr(0, 9'h55, 1); wr(0, 9'hAA, 1); wr(0, 9'h3B, 1); end
         begin
            for (int f = 0; f < 3; f++) rx_frame(0, 104, 8, 0, 1, 0, t[f], p);
         end
      join
      check_val("gap_01", t[1] - t[0], 1040);
      check_val("gap_12", t[2] - t[1], 1040);
      @(negedge clk);
      check_val("busy_after3", busy[0], 0);
      check_val("tx_after3", tx_pin[0], 1);
      check_val("done_cnt3", n_done0 - d0, 3);

      // Even and odd parity on 0x07
      fork wr(1, 9'h07, 1); rx_frame(1, 104, 8, 2, 1, 0, t[0], p); join
      check_val("par_even", p, 1);
      fork wr(2, 9'h07, 1); rx_frame(2, 104, 8, 1, 1, 0, t[0], p); join
      check_val("par_odd", p, 0);
      @(negedge clk);
      check_val("busy_par_end", busy[2], 0);

      // Short 7-bit frame with two stop bits
      fork wr(3, 9'h5A, 1); rx_frame(3, 4, 7, 0, 2, 0, t[0], p); join
      @(negedge clk);
      check_val("busy_d3_end", busy[3], 0);

      // Fill while busy: 16 queued, 17th dropped
      d0 = n_done0;
      o0 = n_ovf0;
      fork
         begin
            wr(0, 9'hC3, 1);
            repeat (3) @(negedge clk);
            check_val("busy_fill", busy[0], 1);
            for (int i = 0; i < 16; i++) begin
               wr(0, 9'(i * 17 + 1), 1);
               check_val("level_fill", level[0], i + 1);
            end
            check_val("full16", full[0], 1);
            wr(0, 9'hEE, 0);
            check_val("ovf_pulse", overflow[0], 1);
            check_val("level_ovf", level[0], 16);
            @(negedge clk);
            check_val("ovf_clear", overflow[0], 0);
         end
         begin
            for (int f = 0; f < 17; f++) rx_frame(0, 104, 8, 0, 1, 0, t[f], p);
         end
      join
      @(negedge clk);
      check_val("n_frames17", n_done0 - d0, 17);
      check_val("n_ovf1", n_ovf0 - o0, 1);
      check_val("empty_after17", empty[0], 1);
      check_val("busy_after17", busy[0], 0);
      check_val("sb_left", sb_q.size(), 0);

      // Write coincident with the pop at the end of a frame
      o0 = n_ovf0;
      fork
         begin
            wr(0, 9'h11, 1);
            repeat (3) @(negedge clk);
            wr(0, 9'h22, 1);
            check_val("level_one", level[0], 1);
            check_val("busy_one", busy[0], 1);
            seen = 1'b0;
            for (int k = 0; k < 2000 && !seen; k++) begin
               @(negedge clk);
               if (tx_done[0]) seen = 1'b1;
            end
            check_val("done_seen", seen, 1);
            wr(0, 9'h33, 1);
            check_val("level_coinc", level[0], 1);
            check_val("ovf_coinc", overflow[0], 0);
         end
         begin
            for (int f = 0; f < 3; f++) rx_frame(0, 104, 8, 0, 1, 0, t[f], p);
         end
      join
      @(negedge clk);
      check_val("n_ovf_coinc", n_ovf0 - o0, 0);

      // Reset during data bit 3, one character still queued
      wr(0, 9'h55, 1);
      wr(0, 9'h99, 1);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         if (tx_pin[0] == 1'b0) seen = 1'b1;
         else @(negedge clk);
      end
      check_val("rst_start_seen", seen, 1);
      repeat (104 + 3 * 104 + 50) @(negedge clk);
      check_val("pre_rst_bit3", tx_pin[0], 0);
      check_val("pre_rst_level", level[0], 1);
      d0 = n_done0;
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_tx_pin", tx_pin[0], 1);
      check_val("arst_empty", empty[0], 1);
      check_val("arst_level", level[0], 0);
      check_val("arst_busy", busy[0], 0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("arst_no_done", n_done0 - d0, 0);

      // Write latency after reset, then the full frame
      wr_en[0] = 1'b1;
      wd[0]    = 9'h3B;
      sb_q.push_back(9'h3B);
      @(negedge clk);
      wr_en[0] = 1'b0;
      check_val("lat_empty", empty[0], 0);
      check_val("lat_tx_high", tx_pin[0], 1);
      @(negedge clk);
      check_val("lat_tx_low", tx_pin[0], 0);
      check_val("lat_level", level[0], 0);
      check_val("lat_busy", busy[0], 1);
      rx_frame(0, 104, 8, 0, 1, 1, t[0], p);
      @(negedge clk);
      check_val("busy_final", busy[0], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
